// File: rtl/pll_lock_monitor.sv
// rtl/pll_lock_monitor.sv - PLL feedback edge-count lock monitor
//
// Counts rising edges of the asynchronous, pre-divided PLL feedback clock over
// a fixed gate window of clk cycles. Each count is checked against target +/- tol,
// and a run of consecutive in-tolerance windows declares lock.
//
// Configuration macro: PLL_LOCK_STICKY_EN
//   defined   - lock_lost is a sticky flag, set on loss of lock, cleared by clr_lost
//   undefined - lock_lost is tied 0 and clr_lost is ignored
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   enable     in   1 = run back-to-back windows, 0 = return to idle
//   pll_fb     in   asynchronous divided PLL feedback clock
//   target     in   expected edges per window, latched at window start
//   tol        in   allowed |count - target|, latched at window start
//   meas_count out  edge count of the last completed window
//   meas_valid out  one-cycle pulse while meas_count holds a fresh result
//   in_tol     out  last completed window was within tolerance
//   locked     out  lock indication
//   lock_lost  out  sticky loss-of-lock flag
//   clr_lost   in   synchronous clear of lock_lost

module pll_lock_monitor #(
    parameter int GATE_CYCLES  = 256,
    parameter int CNT_W        = 12,
    parameter int LOCK_WINDOWS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             pll_fb,
    input  logic [CNT_W-1:0] target,
    input  logic [7:0]       tol,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_valid,
    output logic             in_tol,
    output logic             locked,
    output logic             lock_lost,
    input  logic             clr_lost
);

    localparam int WIN_W = $clog2(GATE_CYCLES);
    // Tolerance compare width: wide enough for both the CNT_W+1 bit
    // magnitude and the 8-bit tolerance.
    localparam int CMP_W = (CNT_W + 1 > 8) ? CNT_W + 1 : 8;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(GATE_CYCLES - 1);
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
    localparam logic [3:0]       GOOD_MAX = 4'(LOCK_WINDOWS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_EVAL    = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       fb_sync_q;
    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [7:0]       tol_q, tol_d;
    logic [CNT_W-1:0] meas_count_q, meas_count_d;
    logic             in_tol_q, in_tol_d;
    logic             locked_q, locked_d;
    logic [3:0]       good_q, good_d;
    logic             loss_event;

    logic             fb_rise;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W:0]   abs_diff;
    logic             within_tol;
    logic [3:0]       good_inc;

    // fb_sync_q[0..1] form the synchronizer, fb_sync_q[2] is the edge-detect
    // history flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fb_sync_q <= 3'b000;
        end else begin
            fb_sync_q <= {fb_sync_q[1:0], pll_fb};
        end
    end

    assign fb_rise = fb_sync_q[1] & ~fb_sync_q[2];

    // Count including a rise in the current cycle, saturating.
    assign cnt_inc = (fb_rise && (cnt_q != CNT_MAX)) ? cnt_q + CNT_ONE : cnt_q;

    // Magnitude formed at CNT_W+1 bits so a count below target never wraps.
    always_comb begin
        abs_diff = '0;
        if (cnt_inc >= target_q) begin
            abs_diff = {1'b0, cnt_inc} - {1'b0, target_q};
        end else begin
            abs_diff = {1'b0, target_q} - {1'b0, cnt_inc};
        end
    end

    assign within_tol = (CMP_W'(abs_diff) <= CMP_W'(tol_q));
    assign good_inc   = (good_q == GOOD_MAX) ? good_q : good_q + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            win_q        <= '0;
            cnt_q        <= '0;
            target_q     <= '0;
            tol_q        <= '0;
            meas_count_q <= '0;
            in_tol_q     <= 1'b0;
            locked_q     <= 1'b0;
            good_q       <= '0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            cnt_q        <= cnt_d;
            target_q     <= target_d;
            tol_q        <= tol_d;
            meas_count_q <= meas_count_d;
            in_tol_q     <= in_tol_d;
            locked_q     <= locked_d;
            good_q       <= good_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        cnt_d        = cnt_q;
        target_d     = target_q;
        tol_d        = tol_q;
        meas_count_d = meas_count_q;
        in_tol_d     = in_tol_q;
        locked_d     = locked_q;
        good_d       = good_q;
        loss_event   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                good_d = '0;
                if (enable) begin
                    state_d  = ST_MEASURE;
                    target_d = target;
                    tol_d    = tol;
                    cnt_d    = '0;
                    win_d    = WIN_LOAD;
                end
            end

            ST_MEASURE: begin
                if (!enable) begin
                    // Partial window is discarded; results hold.
                    state_d = ST_IDLE;
                    good_d  = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (win_q == '0) begin
                        // Results are registered on the way into EVAL so
                        // they are already visible while meas_valid is high.
                        state_d      = ST_EVAL;
                        meas_count_d = cnt_inc;
                        in_tol_d     = within_tol;
                        if (within_tol) begin
                            good_d = good_inc;
                            if (good_inc == GOOD_MAX) begin
                                locked_d = 1'b1;
                            end
                        end else begin
                            good_d     = '0;
                            locked_d   = 1'b0;
                            loss_event = locked_q;
                        end
                    end else begin
                        win_d = win_q - WIN_ONE;
                    end
                end
            end

            ST_EVAL: begin
                // Rises seen here are not counted; the next window starts clean.
                if (enable) begin
                    state_d  = ST_MEASURE;
                    target_d = target;
                    tol_d    = tol;
                    cnt_d    = '0;
                    win_d    = WIN_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign meas_count = meas_count_q;
    assign meas_valid = (state_q == ST_EVAL);
    assign in_tol     = in_tol_q;
    assign locked     = locked_q;

`ifdef PLL_LOCK_STICKY_EN
    logic lock_lost_q;

    // A loss event in the same cycle as clr_lost keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_lost_q <= 1'b0;
        end else if (loss_event) begin
            lock_lost_q <= 1'b1;
        end else if (clr_lost) begin
            lock_lost_q <= 1'b0;
        end
    end

    assign lock_lost = lock_lost_q;
`else
    logic unused_sticky;

    assign unused_sticky = &{1'b0, clr_lost, loss_event};
    assign lock_lost     = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_monitor.sv
// tb/tb_pll_lock_monitor.sv - self-checking bench for pll_lock_monitor

module tb_pll_lock_monitor;

    localparam int GATE  = 256;
    localparam int LOCKW = 4;
    localparam int MAXC  = 20000;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        pll_fb;
    logic [11:0] target;
    logic [7:0]  tol;
    logic        clr_lost;
    logic [11:0] meas_count;
    logic        meas_valid;
    logic        in_tol;
    logic        locked;
    logic        lock_lost;

    logic [3:0]  meas_count4;
    logic        meas_valid4;
    logic        in_tol4;
    logic        locked4;
    logic        lock_lost4;

    int          errors;
    int          checks;
    int          cyc;
    bit          samp [0:MAXC-1];

    int          fb_lo;
    int          fb_hi;
    int          fb_cnt;
    int          fb_half;

    int          win_target;
    int          win_tol;
    int          good_m;
    bit          locked_m;
    bit          lost_m;
    bit          have_prev;
    int          prev_n;
    int          last_n;

    pll_lock_monitor #(.GATE_CYCLES(GATE), .CNT_W(12), .LOCK_WINDOWS(LOCKW)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .pll_fb     (pll_fb),
        .target     (target),
        .tol        (tol),
        .meas_count (meas_count),
        .meas_valid (meas_valid),
        .in_tol     (in_tol),
        .locked     (locked),
        .lock_lost  (lock_lost),
        .clr_lost   (clr_lost)
    );

    pll_lock_monitor #(.GATE_CYCLES(GATE), .CNT_W(4), .LOCK_WINDOWS(LOCKW)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .pll_fb     (pll_fb),
        .target     (target[3:0]),
        .tol        (tol),
        .meas_count (meas_count4),
        .meas_valid (meas_valid4),
        .in_tol     (in_tol4),
        .locked     (locked4),
        .lock_lost  (lock_lost4),
        .clr_lost   (clr_lost)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record pll_fb as seen at every rising clk edge, indexed by edge number.
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (cyc < MAXC) samp[cyc] = pll_fb;
        end
    end

    // Feedback generator: toggles on falling edges after a random number of
    // cycles in [fb_lo, fb_hi]; fb_lo == 0 holds the line low.
    initial begin
        pll_fb  = 1'b0;
        fb_cnt  = 0;
        fb_half = 4;
        forever begin
            @(negedge clk);
            if (fb_lo == 0) begin
                pll_fb = 1'b0;
                fb_cnt = 0;
            end else begin
                fb_cnt++;
                if (fb_cnt >= fb_half) begin
                    pll_fb  = ~pll_fb;
                    fb_cnt  = 0;
                    fb_half = $urandom_range(fb_hi, fb_lo);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // A rise sampled at edge m-2 (low at m-3) is counted at edge m; a window
    // ending at edge n counts the GATE edges n-GATE+1 .. n.
    function automatic int model_count(input int n);
        int c;
        c = 0;
        for (int m = n - GATE + 1; m <= n; m++) begin
            if (m >= 3 && m < MAXC) begin
                if (samp[m-2] && !samp[m-3]) c++;
            end
        end
        return c;
    endfunction

    task automatic set_params(input int t, input int tl);
        target     = t[11:0];
        tol        = tl[7:0];
        win_target = t;
        win_tol    = tl;
    endtask

    task automatic eval_window();
        int k;
        int n;
        int c;
        int c4;
        int d;
        bit it;
        k = 0;
        @(negedge clk);
        while (meas_valid !== 1'b1 && k < 700) begin
            @(negedge clk);
            k++;
        end
        if (meas_valid !== 1'b1) begin
            checks++;
            errors++;
            $error("FAIL mv_timeout: observed=no meas_valid expected=meas_valid within 700 cycles");
            have_prev = 1'b0;
            return;
        end
        n  = cyc;
        c  = model_count(n);
        if (c > 4095) c = 4095;
        c4 = (c > 15) ? 15 : c;
        d  = (c > win_target) ? c - win_target : win_target - c;
        it = (d <= win_tol);
        if (it) begin
            if (good_m < LOCKW) good_m++;
            if (good_m == LOCKW) locked_m = 1'b1;
        end else begin
`ifdef PLL_LOCK_STICKY_EN
            if (locked_m) lost_m = 1'b1;
`endif
            good_m   = 0;
            locked_m = 1'b0;
        end
        chk("meas_count", meas_count, c);
        chk("in_tol", in_tol, it);
        chk("locked", locked, locked_m);
        chk("lock_lost", lock_lost, lost_m);
        chk("meas_valid_w4", meas_valid4, 1);
        chk("meas_count_w4", meas_count4, c4);
        if (have_prev) chk("window_gap", n - prev_n, GATE + 1);
        prev_n    = n;
        last_n    = n;
        have_prev = 1'b1;
    endtask

    initial begin
        int e;
        int mc_hold;
        bit seen;
        errors    = 0;
        checks    = 0;
        good_m    = 0;
        locked_m  = 1'b0;
        lost_m    = 1'b0;
        have_prev = 1'b0;
        prev_n    = 0;
        last_n    = 0;
        rst       = 1'b1;
        enable    = 1'b0;
        clr_lost  = 1'b0;
        fb_lo     = 4;
        fb_hi     = 4;
        set_params(32, 1);

        // Reset state
        repeat (12) @(negedge clk);
        chk("rst_meas_count", meas_count, 0);
        chk("rst_meas_valid", meas_valid, 0);
        chk("rst_in_tol", in_tol, 0);
        chk("rst_locked", locked, 0);
        chk("rst_lock_lost", lock_lost, 0);
        rst = 1'b0;
        @(negedge clk);

        // 80 ns feedback, target 32 +/- 1: lock on the fourth window
        enable = 1'b1;
        e = cyc + 1;
        eval_window();
        chk("first_eval_edge", last_n, e + GATE);
        @(negedge clk);
        chk("meas_valid_pulse", meas_valid, 0);
        eval_window();
        eval_window();
        chk("not_locked_at_3rd", locked, 0);
        eval_window();
        chk("locked_at_4th", locked, 1);

        // 60 ns feedback: loss of lock
        fb_lo = 3;
        fb_hi = 3;
        eval_window();
        chk("loss_in_tol", in_tol, 0);
        chk("loss_locked", locked, 0);
`ifdef PLL_LOCK_STICKY_EN
        chk("loss_sticky", lock_lost, 1);
`else
        chk("loss_sticky", lock_lost, 0);
`endif
        clr_lost = 1'b1;
        @(negedge clk);
        clr_lost = 1'b0;
        lost_m   = 1'b0;
        @(negedge clk);
        chk("clr_lost", lock_lost, 0);

        // Randomized feedback jitter and parameters
        eval_window();
        for (int i = 0; i < 8; i++) begin
            fb_lo = $urandom_range(5, 2);
            fb_hi = fb_lo + $urandom_range(2, 0);
            set_params(GATE / (fb_lo + fb_hi) + $urandom_range(4, 0) - 2, $urandom_range(3, 0));
            eval_window();
        end

        // No edges: target 0 tol 0 matches, target 5 does not and must not wrap
        fb_lo = 0;
        set_params(0, 0);
        eval_window();
        eval_window();
        chk("zero_count", meas_count, 0);
        chk("zero_in_tol", in_tol, 1);
        set_params(5, 0);
        eval_window();
        chk("under_target_in_tol", in_tol, 0);

        // 20 ns feedback: 4-bit counter saturates
        fb_lo = 1;
        fb_hi = 1;
        set_params(128, 0);
        eval_window();
        eval_window();
        chk("sat_count_w4", meas_count4, 15);
        chk("full_count", meas_count, 128);

        // Relock, then abort a window at cycle 100
        fb_lo = 4;
        fb_hi = 4;
        set_params(32, 1);
        for (int i = 0; i < 5; i++) eval_window();
        chk("relocked", locked, 1);
        mc_hold = meas_count;
        repeat (100) @(negedge clk);
        enable    = 1'b0;
        good_m    = 0;
        have_prev = 1'b0;
        seen      = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (meas_valid === 1'b1) seen = 1'b1;
        end
        chk("no_partial_mv", seen, 0);
        chk("abort_hold_count", meas_count, mc_hold);
        chk("abort_hold_locked", locked, 1);
        enable = 1'b1;
        e = cyc + 1;
        eval_window();
        chk("reentry_eval_edge", last_n, e + GATE);
        eval_window();

        // Asynchronous reset mid-window while locked
        repeat (50) @(negedge clk);
        chk("pre_rst_locked", locked, 1);
        rst = 1'b1;
        #1;
        chk("arst_meas_count", meas_count, 0);
        chk("arst_meas_valid", meas_valid, 0);
        chk("arst_in_tol", in_tol, 0);
        chk("arst_locked", locked, 0);
        chk("arst_lock_lost", lock_lost, 0);
        repeat (300) @(negedge clk);
        chk("rst_hold_mv", meas_valid, 0);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
